// File: rtl/simon_input_loader.sv
// Input deserialiser for the Simon 32/64 core: gathers C key beats and C plaintext
// beats (most-significant first) into one key word and one block, then offers them downstream.
module simon_input_loader #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int C = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     key,
    input  logic [M-1:0]     Plaintxt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N*C-1:0]   key_word,
    output logic [M*C-1:0]   pt_word,
    output logic             busy,
    output logic             short_err,
    output logic [1:0]       state_dbg
);

    // Handshake: a block transfers on a rising edge where out_valid && out_ready.
    // out_valid, once high, holds with stable data until that edge; out_ready is
    // ignored while no block is held, and start is ignored on the transfer edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int CW = $clog2(C + 1);
    localparam logic [CW-1:0] LAST = CW'(C - 1);

    state_t          state;
    logic [CW-1:0]   beat_cnt;
    logic [N*C-1:0]  key_sr;
    logic [M*C-1:0]  pt_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            key_sr    <= '0;
            pt_sr     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            short_err <= 1'b0;
        end else begin
            short_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_sr <= {key_sr[N*C-N-1:0], key};
                        pt_sr  <= {pt_sr[M*C-M-1:0], Plaintxt};
                        busy   <= 1'b1;
                        if (C == 1) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                            beat_cnt  <= '0;
                        end else begin
                            state    <= LOAD;
                            beat_cnt <= CW'(1);
                        end
                    end
                end
                LOAD: begin
                    if (start) begin
                        key_sr <= {key_sr[N*C-N-1:0], key};
                        pt_sr  <= {pt_sr[M*C-M-1:0], Plaintxt};
                        if (beat_cnt == LAST) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end else begin
                        // Truncated stream: drop the partial block so it cannot leak into the next one.
                        state     <= IDLE;
                        short_err <= 1'b1;
                        beat_cnt  <= '0;
                        key_sr    <= '0;
                        pt_sr     <= '0;
                        busy      <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    beat_cnt  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign key_word  = key_sr;
    assign pt_word   = pt_sr;
    assign state_dbg = state;

endmodule

// File: tb/tb_simon_input_loader.sv
// Bench for simon_input_loader: directed scenarios plus random streams, words
// predicted arithmetically from the beat arrays and queued until transfer.
module tb_simon_input_loader;

    localparam int N = 8;
    localparam int M = 4;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   key;
    logic [M-1:0]   Plaintxt;
    logic           out_ready;
    logic           out_valid;
    logic [N*C-1:0] key_word;
    logic [M*C-1:0] pt_word;
    logic           busy;
    logic           short_err;
    logic [1:0]     state_dbg;

    simon_input_loader #(.N(N), .M(M), .C(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .Plaintxt  (Plaintxt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .key_word  (key_word),
        .pt_word   (pt_word),
        .busy      (busy),
        .short_err (short_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [N*C+M*C-1:0] exp_q[$];
    logic [N-1:0] kb[C];
    logic [M-1:0] pb[C];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: first beat is the most significant digit of the word.
    function automatic logic [N*C+M*C-1:0] model_block();
        logic [N*C-1:0] k;
        logic [M*C-1:0] p;
        k = '0;
        p = '0;
        for (int i = 0; i < C; i++) begin
            k = k * (2 ** N) + (N*C)'(kb[i]);
            p = p * (2 ** M) + (M*C)'(pb[i]);
        end
        return {k, p};
    endfunction

    task automatic random_beats();
        for (int i = 0; i < C; i++) begin
            kb[i] = N'($urandom_range(0, 2**N - 1));
            pb[i] = M'($urandom_range(0, 2**M - 1));
        end
    endtask

    task automatic load_stream(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            start    = 1'b1;
            key      = kb[i];
            Plaintxt = pb[i];
            step();
            chk("valid_during_load", out_valid, (i == C - 1) ? 64'd1 : 64'd0);
            chk("busy_during_load", busy, 64'd1);
        end
        if (nbeats == C) exp_q.push_back(model_block());
        start = 1'b0;
    endtask

    task automatic expect_block(input string tag);
        logic [N*C+M*C-1:0] e;
        chk({tag, "_valid"}, out_valid, 64'd1);
        chk({tag, "_short_err"}, short_err, 64'd0);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q[0];
            chk({tag, "_key"}, key_word, e[N*C+M*C-1:M*C]);
            chk({tag, "_pt"}, pt_word, e[M*C-1:0]);
        end
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        step();
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk({tag, "_valid_drop"}, out_valid, 64'd0);
        chk({tag, "_idle"}, busy, 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [N*C-1:0] held_key;
        logic [M*C-1:0] held_pt;

        // 1: reset held with random inputs
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom_range(0, 1));
            key       = N'($urandom);
            Plaintxt  = M'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
            chk("rst_valid", out_valid, 64'd0);
            chk("rst_busy", busy, 64'd0);
            chk("rst_short_err", short_err, 64'd0);
            chk("rst_key", key_word, 64'd0);
            chk("rst_pt", pt_word, 64'd0);
        end
        start = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_busy", busy, 64'd0);
        chk("post_rst_valid", out_valid, 64'd0);

        // 2: nominal vector
        kb = '{8'h19, 8'h18, 8'h11, 8'h10, 8'h09, 8'h08, 8'h01, 8'h00};
        pb = '{4'h6, 4'h5, 4'h6, 4'h5, 4'h6, 4'h8, 4'h7, 4'h7};
        load_stream(C);
        expect_block("nominal");
        chk("nominal_key_const", key_word, 64'h1918111009080100);
        chk("nominal_pt_const", pt_word, 64'h65656877);
        drain("nominal");

        // 3: backpressure for 5 cycles
        load_stream(C);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_block("backpressure");
        end
        drain("backpressure");

        // 4: early stop after 5 beats, then a clean stream
        random_beats();
        load_stream(5);
        step();
        chk("short_err_pulse", short_err, 64'd1);
        chk("short_valid", out_valid, 64'd0);
        chk("short_busy", busy, 64'd0);
        step();
        chk("short_err_once", short_err, 64'd0);
        random_beats();
        load_stream(C);
        expect_block("after_short");
        drain("after_short");

        // 5: beats ignored while FULL, stream continues straight after the transfer
        random_beats();
        load_stream(C);
        held_key = key_word;
        held_pt  = pt_word;
        start    = 1'b1;
        key      = 8'hAA;
        Plaintxt = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_block("full_ignore");
            chk("full_key_stable", key_word, held_key);
            chk("full_pt_stable", pt_word, held_pt);
        end
        drain("full_ignore");
        random_beats();
        load_stream(C);
        expect_block("fresh_after_full");
        drain("fresh_after_full");

        // 6: async reset mid-load
        random_beats();
        load_stream(4);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", out_valid, 64'd0);
        chk("async_busy", busy, 64'd0);
        chk("async_short_err", short_err, 64'd0);
        chk("async_key", key_word, 64'd0);
        chk("async_pt", pt_word, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("async_no_err", short_err, 64'd0);
        random_beats();
        load_stream(C);
        expect_block("after_async");
        drain("after_async");

        // random streams with random backpressure
        for (int r = 0; r < 8; r++) begin
            int wait_cycles;
            random_beats();
            load_stream(C);
            wait_cycles = $urandom_range(0, 4);
            for (int w = 0; w < wait_cycles; w++) begin
                start = 1'($urandom_range(0, 1));
                key   = N'($urandom);
                step();
                expect_block("rand_wait");
            end
            start = 1'b0;
            expect_block("rand");
            drain("rand");
            if ($urandom_range(0, 1) == 1) step();
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
